// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - FIFO-fed APB command master; define APB_CMD_PREADY_EN for pready wait states and timeout
module apb_cmd_master #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic         sys_clk,
  input  logic         rst_b,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic         cmd_sel,
  input  logic [N-1:0] cmd_addr,
  input  logic [N-1:0] cmd_wdata,
  output logic         rsp_valid,
  output logic         rsp_write,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         busy,
  output logic [N-1:0] apb_xx_paddr,
  output logic [N-1:0] apb_xx_pwdata,
  output logic         apb_xx_pwrite,
  output logic         apb_xx_penable,
  output logic         apb_slavex_psel0,
  output logic         apb_slavex_psel1,
`ifdef APB_CMD_PREADY_EN
  input  logic         apb_xx_pready,
`endif
  input  logic [N-1:0] slavex0_apb_prdata,
  input  logic [N-1:0] slavex1_apb_prdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = 2 + 2 * N;
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_GAP} state_t;

  state_t         state, state_nx;
  logic [FW-1:0]  mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full, push, pop;
  logic           done, err;
  logic           h_write, h_sel;
  logic [N-1:0]   h_addr, h_wdata;
  logic [3:0]     gap_cnt;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_write, cmd_sel, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      h_write <= 1'b0;
      h_sel   <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
    end else if (pop) begin
      {h_write, h_sel, h_addr, h_wdata} <= mem[rd_ptr[AW-1:0]];
    end
  end

`ifdef APB_CMD_PREADY_EN
  logic [3:0] wait_cnt;

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b)                                     wait_cnt <= 4'd0;
    else if (state == ST_ACCESS && !apb_xx_pready)  wait_cnt <= wait_cnt + 4'd1;
    else                                            wait_cnt <= 4'd0;
  end
`endif

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = ST_SETUP;
        end
      end
      ST_SETUP: state_nx = ST_ACCESS;
      ST_ACCESS: begin
`ifdef APB_CMD_PREADY_EN
        // Sixteenth straight low-pready cycle ends the transfer as a timeout
        if (apb_xx_pready) begin
          done = 1'b1;
        end else if (wait_cnt == 4'd15) begin
          done = 1'b1;
          err  = 1'b1;
        end
`else
        done = 1'b1;
`endif
        if (done) state_nx = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b)                gap_cnt <= 4'd0;
    else if (state == ST_GAP)  gap_cnt <= gap_cnt + 4'd1;
    else                       gap_cnt <= 4'd0;
  end

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_write <= h_write;
        rsp_err   <= err;
        rsp_rdata <= (h_write || err) ? '0 : (h_sel ? slavex1_apb_prdata : slavex0_apb_prdata);
      end
    end
  end

  assign apb_xx_paddr     = h_addr;
  assign apb_xx_pwdata    = h_wdata;
  assign apb_xx_pwrite    = h_write;
  assign apb_xx_penable   = (state == ST_ACCESS);
  assign apb_slavex_psel0 = (state == ST_SETUP || state == ST_ACCESS) && !h_sel;
  assign apb_slavex_psel1 = (state == ST_SETUP || state == ST_ACCESS) && h_sel;
  assign busy             = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed bench for apb_cmd_master at GAP=0 and GAP=2
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cmd_valid0, cmd_valid2, cmd_write, cmd_sel;
  logic [31:0] cmd_addr, cmd_wdata, prdata0, prdata1;
`ifdef APB_CMD_PREADY_EN
  logic        pready;
`endif

  logic        d0_ready, d0_rv, d0_rw, d0_rerr, d0_busy, d0_pwrite, d0_pen, d0_psel0, d0_psel1;
  logic [31:0] d0_rdata, d0_paddr, d0_pwdata;
  logic        d2_ready, d2_rv, d2_rw, d2_rerr, d2_busy, d2_pwrite, d2_pen, d2_psel0, d2_psel1;
  logic [31:0] d2_rdata, d2_paddr, d2_pwdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int          q0_cyc[$];
  logic [31:0] q0_addr[$];
  int          q2_cyc[$];
  logic [31:0] q2_addr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every SETUP phase (select high, enable low) with its cycle number
  always @(negedge clk) begin
    if ((d0_psel0 || d0_psel1) && !d0_pen) begin
      q0_cyc.push_back(cyc);
      q0_addr.push_back(d0_paddr);
    end
    if ((d2_psel0 || d2_psel1) && !d2_pen) begin
      q2_cyc.push_back(cyc);
      q2_addr.push_back(d2_paddr);
    end
  end

  apb_cmd_master #(.N(32), .DEPTH(4), .GAP(0)) u_dut0 (
    .sys_clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid0), .cmd_ready(d0_ready),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(d0_rv), .rsp_write(d0_rw), .rsp_rdata(d0_rdata), .rsp_err(d0_rerr), .busy(d0_busy),
    .apb_xx_paddr(d0_paddr), .apb_xx_pwdata(d0_pwdata), .apb_xx_pwrite(d0_pwrite),
    .apb_xx_penable(d0_pen), .apb_slavex_psel0(d0_psel0), .apb_slavex_psel1(d0_psel1),
`ifdef APB_CMD_PREADY_EN
    .apb_xx_pready(pready),
`endif
    .slavex0_apb_prdata(prdata0), .slavex1_apb_prdata(prdata1)
  );

  apb_cmd_master #(.N(32), .DEPTH(4), .GAP(2)) u_dut2 (
    .sys_clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid2), .cmd_ready(d2_ready),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(d2_rv), .rsp_write(d2_rw), .rsp_rdata(d2_rdata), .rsp_err(d2_rerr), .busy(d2_busy),
    .apb_xx_paddr(d2_paddr), .apb_xx_pwdata(d2_pwdata), .apb_xx_pwrite(d2_pwrite),
    .apb_xx_penable(d2_pen), .apb_slavex_psel0(d2_psel0), .apb_slavex_psel1(d2_psel1),
`ifdef APB_CMD_PREADY_EN
    .apb_xx_pready(pready),
`endif
    .slavex0_apb_prdata(prdata0), .slavex1_apb_prdata(prdata1)
  );

  task automatic test_reset;
    rst_b = 1'b0;
    cmd_valid0 = 1'b0; cmd_valid2 = 1'b0;
    cmd_write = 1'b0; cmd_sel = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata0 = 32'h0000_1234; prdata1 = 32'hDEAD_BEEF;
`ifdef APB_CMD_PREADY_EN
    pready = 1'b1;
`endif
    repeat (3) @(negedge clk);
    vectors++; if (d0_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready got=%0b exp=1", d0_ready); end
    vectors++; if (d0_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%0b exp=0", d0_busy); end
    vectors++; if ({d0_psel0, d0_psel1, d0_pen, d0_pwrite} !== 4'b0) begin miscompares++; $display("FAIL rst_ctrl got=%b exp=0000", {d0_psel0, d0_psel1, d0_pen, d0_pwrite}); end
    vectors++; if ({d0_paddr, d0_pwdata} !== 64'h0) begin miscompares++; $display("FAIL rst_bus got=%h exp=0", {d0_paddr, d0_pwdata}); end
    vectors++; if ({d0_rv, d0_rw, d0_rerr, d0_rdata} !== 35'h0) begin miscompares++; $display("FAIL rst_rsp got=%h exp=0", {d0_rv, d0_rw, d0_rerr, d0_rdata}); end
    @(posedge clk); #1 rst_b = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write;
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_sel = 1'b1; cmd_addr = 32'h0000_000C; cmd_wdata = 32'hFFEE_DD66; cmd_valid0 = 1'b1;
    @(negedge clk);
    vectors++; if (d0_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready got=%0b exp=1", d0_ready); end
    @(posedge clk); #1 cmd_valid0 = 1'b0;
    @(negedge clk);
    vectors++; if (d0_psel1 !== 1'b0) begin miscompares++; $display("FAIL wr_c1_psel1 got=%0b exp=0", d0_psel1); end
    @(negedge clk);
    vectors++; if ({d0_psel1, d0_psel0, d0_pen, d0_pwrite} !== 4'b1001) begin miscompares++; $display("FAIL wr_setup got=%b exp=1001", {d0_psel1, d0_psel0, d0_pen, d0_pwrite}); end
    vectors++; if (d0_paddr !== 32'h0000_000C) begin miscompares++; $display("FAIL wr_paddr got=%h exp=0000000c", d0_paddr); end
    vectors++; if (d0_pwdata !== 32'hFFEE_DD66) begin miscompares++; $display("FAIL wr_pwdata got=%h exp=ffeedd66", d0_pwdata); end
    @(negedge clk);
    vectors++; if ({d0_psel1, d0_psel0, d0_pen} !== 3'b101) begin miscompares++; $display("FAIL wr_access got=%b exp=101", {d0_psel1, d0_psel0, d0_pen}); end
    vectors++; if (d0_rv !== 1'b0) begin miscompares++; $display("FAIL wr_early_rsp got=%0b exp=0", d0_rv); end
    @(negedge clk);
    vectors++; if ({d0_rv, d0_rw, d0_rerr} !== 3'b110) begin miscompares++; $display("FAIL wr_rsp got=%b exp=110", {d0_rv, d0_rw, d0_rerr}); end
    vectors++; if (d0_rdata !== 32'h0) begin miscompares++; $display("FAIL wr_rdata got=%h exp=0", d0_rdata); end
    vectors++; if ({d0_psel1, d0_pen} !== 2'b00) begin miscompares++; $display("FAIL wr_release got=%b exp=00", {d0_psel1, d0_pen}); end
    @(negedge clk);
    vectors++; if ({d0_rv, d0_rw} !== 2'b01) begin miscompares++; $display("FAIL wr_pulse_hold got=%b exp=01", {d0_rv, d0_rw}); end
    vectors++; if ({d0_paddr, d0_pwdata, d0_pwrite} !== {32'h0000_000C, 32'hFFEE_DD66, 1'b1}) begin miscompares++; $display("FAIL wr_bus_hold got=%h exp=%h", {d0_paddr, d0_pwdata, d0_pwrite}, {32'h0000_000C, 32'hFFEE_DD66, 1'b1}); end
    vectors++; if (d0_busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy got=%0b exp=0", d0_busy); end
  endtask

  task automatic test_read;
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_sel = 1'b0; cmd_addr = 32'h0000_0008; cmd_wdata = 32'h5555_AAAA; cmd_valid0 = 1'b1;
    @(posedge clk); #1 cmd_valid0 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if ({d0_psel0, d0_psel1, d0_pen, d0_pwrite} !== 4'b1000) begin miscompares++; $display("FAIL rd_setup got=%b exp=1000", {d0_psel0, d0_psel1, d0_pen, d0_pwrite}); end
    vectors++; if (d0_paddr !== 32'h0000_0008) begin miscompares++; $display("FAIL rd_paddr got=%h exp=00000008", d0_paddr); end
    @(negedge clk);
    vectors++; if ({d0_psel0, d0_psel1, d0_pen} !== 3'b101) begin miscompares++; $display("FAIL rd_access got=%b exp=101", {d0_psel0, d0_psel1, d0_pen}); end
    @(negedge clk);
    vectors++; if ({d0_rv, d0_rw, d0_rerr} !== 3'b100) begin miscompares++; $display("FAIL rd_rsp got=%b exp=100", {d0_rv, d0_rw, d0_rerr}); end
    vectors++; if (d0_rdata !== 32'h0000_1234) begin miscompares++; $display("FAIL rd_rdata got=%h exp=00001234", d0_rdata); end
  endtask

  task automatic test_back_to_back;
    int base;
    int acc;
    q0_cyc.delete(); q0_addr.delete();
    @(posedge clk); #1 base = cyc;
    for (int i = 0; i < 6; i++) begin
      cmd_write = 1'b1; cmd_sel = i[0]; cmd_addr = 32'h100 + 32'(4 * i); cmd_wdata = 32'(i); cmd_valid0 = 1'b1;
      @(negedge clk);
      vectors++; if (d0_ready !== 1'b1) begin miscompares++; $display("FAIL b2b0_ready[%0d] got=%0b exp=1", i, d0_ready); end
      @(posedge clk); #1;
    end
    cmd_sel = 1'b0; cmd_addr = 32'h118; cmd_wdata = 32'd6;
    @(negedge clk);
    vectors++; if (d0_ready !== 1'b0) begin miscompares++; $display("FAIL b2b0_full got=%0b exp=0", d0_ready); end
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d0_ready) begin acc = cyc - base; break; end
    end
    @(posedge clk); #1 cmd_valid0 = 1'b0;
    vectors++; if (acc != 8) begin miscompares++; $display("FAIL b2b0_accept_cycle got=%0d exp=8", acc); end
    for (int k = 0; k < 80 && q0_cyc.size() < 7; k++) @(negedge clk);
    vectors++; if (q0_cyc.size() != 7) begin miscompares++; $display("FAIL b2b0_count got=%0d exp=7", q0_cyc.size()); end
    for (int i = 0; i < 7 && i < q0_cyc.size(); i++) begin
      vectors++; if (q0_addr[i] !== 32'h100 + 32'(4 * i)) begin miscompares++; $display("FAIL b2b0_order[%0d] got=%h exp=%h", i, q0_addr[i], 32'h100 + 32'(4 * i)); end
      vectors++; if (q0_cyc[i] - base != 2 + 3 * i) begin miscompares++; $display("FAIL b2b0_setup_cyc[%0d] got=%0d exp=%0d", i, q0_cyc[i] - base, 2 + 3 * i); end
    end

    q2_cyc.delete(); q2_addr.delete();
    @(posedge clk); #1 base = cyc;
    for (int i = 0; i < 5; i++) begin
      cmd_write = 1'b0; cmd_sel = i[0]; cmd_addr = 32'h200 + 32'(4 * i); cmd_valid0 = 1'b0; cmd_valid2 = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid2 = 1'b0;
    @(negedge clk);
    vectors++; if (d2_ready !== 1'b0) begin miscompares++; $display("FAIL b2b2_full got=%0b exp=0", d2_ready); end
    for (int k = 0; k < 80 && q2_cyc.size() < 5; k++) @(negedge clk);
    vectors++; if (q2_cyc.size() != 5) begin miscompares++; $display("FAIL b2b2_count got=%0d exp=5", q2_cyc.size()); end
    for (int i = 0; i < 5 && i < q2_cyc.size(); i++) begin
      vectors++; if (q2_addr[i] !== 32'h200 + 32'(4 * i)) begin miscompares++; $display("FAIL b2b2_order[%0d] got=%h exp=%h", i, q2_addr[i], 32'h200 + 32'(4 * i)); end
      vectors++; if (q2_cyc[i] - base != 2 + 5 * i) begin miscompares++; $display("FAIL b2b2_setup_cyc[%0d] got=%0d exp=%0d", i, q2_cyc[i] - base, 2 + 5 * i); end
    end
    while (cyc - base < 30) @(negedge clk);
    vectors++; if ({d2_busy, d0_busy} !== 2'b00) begin miscompares++; $display("FAIL b2b_idle_busy got=%b exp=00", {d2_busy, d0_busy}); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cmd_write = 1'b1; cmd_sel = 1'b0; cmd_addr = 32'h300 + 32'(4 * i); cmd_wdata = 32'hA0 + 32'(i); cmd_valid0 = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid0 = 1'b0;
    @(negedge clk);
    vectors++; if ({d0_psel0, d0_pen} !== 2'b11) begin miscompares++; $display("FAIL rstmid_in_access got=%b exp=11", {d0_psel0, d0_pen}); end
    rst_b = 1'b0;
    #1;
    vectors++; if ({d0_psel0, d0_psel1, d0_pen} !== 3'b000) begin miscompares++; $display("FAIL rstmid_drop got=%b exp=000", {d0_psel0, d0_psel1, d0_pen}); end
    vectors++; if ({d0_ready, d0_busy} !== 2'b10) begin miscompares++; $display("FAIL rstmid_ready_busy got=%b exp=10", {d0_ready, d0_busy}); end
    @(negedge clk);
    vectors++; if (d0_rv !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_rsp got=%0b exp=0", d0_rv); end
    @(posedge clk); #1 rst_b = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d0_psel0 || d0_psel1 || d0_rv || d0_busy || !d0_ready) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_flushed got=%0b exp=0", seen); end
  endtask

`ifdef APB_CMD_PREADY_EN
  task automatic test_wait_states;
    int n_acc;
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_sel = 1'b1; cmd_addr = 32'h40; pready = 1'b0; cmd_valid0 = 1'b1;
    @(posedge clk); #1 cmd_valid0 = 1'b0;
    n_acc = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 6) pready = 1'b1;
      @(negedge clk);
      if (k < 7 && d0_pen) n_acc++;
      if (k == 7) begin
        vectors++; if ({d0_rv, d0_rerr} !== 2'b10) begin miscompares++; $display("FAIL ws_rsp got=%b exp=10", {d0_rv, d0_rerr}); end
        vectors++; if (d0_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ws_rdata got=%h exp=deadbeef", d0_rdata); end
      end
      @(posedge clk); #1;
    end
    vectors++; if (n_acc != 4) begin miscompares++; $display("FAIL ws_access_len got=%0d exp=4", n_acc); end

    @(posedge clk); #1;
    pready = 1'b0; cmd_valid0 = 1'b1;
    @(posedge clk); #1 cmd_valid0 = 1'b0;
    n_acc = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k < 19 && d0_pen) n_acc++;
      if (k == 19) begin
        vectors++; if ({d0_rv, d0_rerr} !== 2'b11) begin miscompares++; $display("FAIL to_rsp got=%b exp=11", {d0_rv, d0_rerr}); end
        vectors++; if (d0_rdata !== 32'h0) begin miscompares++; $display("FAIL to_rdata got=%h exp=0", d0_rdata); end
      end
      @(posedge clk); #1;
    end
    vectors++; if (n_acc != 16) begin miscompares++; $display("FAIL to_access_len got=%0d exp=16", n_acc); end
    pready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_CMD_PREADY_EN
    test_wait_states();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
